// File: rtl/l2_arbiter.sv
// Two-port arbiter between the split L1 caches and the shared L2.
// Grants one line transaction at a time, round-robin on ties, and returns the L2 line with a one-cycle pulse.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic              d_read,
  input  logic              d_write,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  output logic              l2_read,
  output logic              l2_write,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t            state_q, state_d;
  port_t             grant_q, grant_d;
  port_t             last_grant_q, last_grant_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic              i_req;
  logic              d_req;
  logic              any_req;
  port_t             winner;

  // Tie goes to whichever port was not served last.
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    any_req = i_req | d_req;
    winner  = PORT_I;
    if (i_req && d_req) begin
      winner = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      winner = PORT_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (l2_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only at grant, so requester changes during BUSY are ignored.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    if (state_q == IDLE && any_req) begin
      grant_d      = winner;
      last_grant_d = winner;
      if (winner == PORT_D) begin
        addr_d     = d_address;
        wdata_d    = d_wdata;
        op_write_d = d_write;
      end else begin
        addr_d     = i_address;
        op_write_d = 1'b0;
      end
    end
    if (state_q == BUSY && l2_resp && !op_write_q) begin
      if (grant_q == PORT_I) begin
        i_rdata_d = l2_rdata;
      end else begin
        d_rdata_d = l2_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= PORT_I;
      last_grant_q <= PORT_D;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Strobes and pulses decode straight from state flops, so reset clears them asynchronously.
  always_comb begin
    l2_read  = (state_q == BUSY) && !op_write_q;
    l2_write = (state_q == BUSY) && op_write_q;
    i_resp   = (state_q == DONE) && (grant_q == PORT_I);
    d_resp   = (state_q == DONE) && (grant_q == PORT_D);
  end

  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: a vector table plus hand-written corner sequences,
// with a response scoreboard that pops expectations whenever a resp pulse appears.
module tb_l2_arbiter;

  logic         clk;
  logic         rst_n;
  logic [15:0]  i_address;
  logic         i_read;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic         d_read;
  logic         d_write;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_read;
  logic         l2_write;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_wdata(d_wdata), .d_read(d_read), .d_write(d_write),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           lat;
    logic [127:0] l2data;
    logic         exp_d;
    logic         exp_wr;
    logic [127:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic         is_d;
    logic [127:0] i_rd;
    logic [127:0] d_rd;
  } exp_t;

  localparam logic [127:0] JUNK = {4{32'hFFFF0000}};

  vec_t         vecs [6];
  exp_t         sb [$];
  logic [127:0] mdl_i;
  logic [127:0] mdl_d;
  int           checks;
  int           errors;
  int           resp_seen;
  int           resp_pushed;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic is_d, input logic [127:0] rdata_after);
    exp_t e;
    if (is_d) mdl_d = rdata_after;
    else      mdl_i = rdata_after;
    e.is_d = is_d;
    e.i_rd = mdl_i;
    e.d_rd = mdl_d;
    sb.push_back(e);
    resp_pushed++;
  endtask

  // Entered at the negedge of the IDLE cycle with the request already driven; leaves at the negedge of the following IDLE cycle.
  task automatic serve(input logic exp_d, input logic exp_wr, input logic [15:0] addr,
                       input logic [127:0] wd, input int lat, input logic [127:0] rd, input int drop_at);
    @(posedge clk); @(negedge clk);
    for (int c = 1; c <= lat; c++) begin
      if (c == drop_at) begin
        d_read  = 1'b0;
        d_write = 1'b0;
        d_address = 16'hBEEF;
      end
      checkOutput("l2_read", l2_read, !exp_wr);
      checkOutput("l2_write", l2_write, exp_wr);
      checkOutput("l2_address", l2_address, addr);
      if (exp_wr) checkOutput("l2_wdata", l2_wdata, wd);
      l2_resp  = (c == lat);
      l2_rdata = (c == lat) ? rd : JUNK;
      @(posedge clk); @(negedge clk);
    end
    l2_resp  = 1'b0;
    l2_rdata = JUNK;
    checkOutput("done_l2_read", l2_read, 0);
    checkOutput("done_l2_write", l2_write, 0);
    checkOutput("done_i_resp", i_resp, !exp_d);
    checkOutput("done_d_resp", d_resp, exp_d);
    if (exp_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    checkOutput("idle_i_resp", i_resp, 0);
    checkOutput("idle_d_resp", d_resp, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    i_read    = v.i_rd;
    d_read    = v.d_rd;
    d_write   = v.d_wr;
    i_address = v.i_rd ? v.addr : 16'h0;
    d_address = v.i_rd ? 16'h0 : v.addr;
    d_wdata   = v.wdata;
    pushExpected(v.exp_d, v.exp_rdata);
    serve(v.exp_d, v.exp_wr, v.addr, v.wdata, v.lat, v.l2data, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    sb.delete();
    mdl_i = '0;
    mdl_d = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard: every resp pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (i_resp || d_resp)) begin
      exp_t e;
      resp_seen++;
      checkOutput("resp_exclusive", {127'b0, i_resp & d_resp}, 128'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_port", {127'b0, d_resp}, {127'b0, e.is_d});
        checkOutput("i_rdata", i_rdata, e.i_rd);
        checkOutput("d_rdata", d_rdata, e.d_rd);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0; errors = 0; resp_seen = 0; resp_pushed = 0;
    mdl_i = '0; mdl_d = '0;
    rst_n = 1'b0;
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_wdata = '0; d_read = 1'b0; d_write = 1'b0;
    l2_rdata = JUNK; l2_resp = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 128'h0, 5, {8{16'hAAAA}},
                1'b0, 1'b0, {8{16'hAAAA}}};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h4440, {8{16'h5555}}, 3, {4{32'hDEADBEEF}},
                1'b1, 1'b1, 128'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0800, 128'h0, 1, 128'h0123456789ABCDEF_FEDCBA9876543210,
                1'b1, 1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h2000, {16{8'h0F}}, 2, {4{32'hBAADF00D}},
                1'b1, 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'hFFF0, 128'h0, 1, {128{1'b1}},
                1'b0, 1'b0, {128{1'b1}}};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, {4{32'h13579BDF}}, 7, {4{32'h0BADC0DE}},
                1'b1, 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210};

    repeat (2) @(negedge clk);
    checkOutput("rst_l2_read", l2_read, 0);
    checkOutput("rst_l2_write", l2_write, 0);
    checkOutput("rst_i_resp", i_resp, 0);
    checkOutput("rst_d_resp", d_resp, 0);
    checkOutput("rst_l2_address", l2_address, 0);
    checkOutput("rst_l2_wdata", l2_wdata, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 6; n++) applyStimulus(vecs[n]);

    // Spurious L2 response in IDLE, then a conflicting read+write presented while it is still high.
    l2_resp  = 1'b1;
    l2_rdata = {4{32'h5A5A5A5A}};
    @(posedge clk); @(negedge clk);
    checkOutput("spur_l2_read", l2_read, 0);
    checkOutput("spur_l2_write", l2_write, 0);
    checkOutput("spur_i_rdata", i_rdata, mdl_i);
    checkOutput("spur_d_rdata", d_rdata, mdl_d);
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h2220; d_wdata = {4{32'h2468ACE0}};
    pushExpected(1'b1, mdl_d);
    serve(1'b1, 1'b1, 16'h2220, {4{32'h2468ACE0}}, 3, {4{32'h77777777}}, 0);

    // Read dropped two cycles into BUSY must still complete unchanged.
    d_read = 1'b1; d_address = 16'h3330;
    pushExpected(1'b1, {4{32'hCAFEF00D}});
    serve(1'b1, 1'b0, 16'h3330, 128'h0, 5, {4{32'hCAFEF00D}}, 3);

    // Reset in the middle of a read abandons it without a response.
    i_read = 1'b1; i_address = 16'h0450;
    @(posedge clk); @(negedge clk);
    checkOutput("prerst_l2_read", l2_read, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_l2_read", l2_read, 0);
    checkOutput("midrst_i_resp", i_resp, 0);
    checkOutput("midrst_i_rdata", i_rdata, 0);
    checkOutput("midrst_d_rdata", d_rdata, 0);
    i_read = 1'b0;
    mdl_i = '0; mdl_d = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("postrst_l2_read", l2_read, 0);
    checkOutput("postrst_i_resp", i_resp, 0);
    i_read = 1'b1; i_address = 16'h0460;
    pushExpected(1'b0, {4{32'h600DCAFE}});
    serve(1'b0, 1'b0, 16'h0460, 128'h0, 2, {4{32'h600DCAFE}}, 0);

    // Two simultaneous pairs after reset: I then D each time.
    doReset();
    for (int p = 0; p < 2; p++) begin
      logic [127:0] rd_i;
      logic [127:0] rd_d;
      rd_i = {4{32'h11110000 + p}};
      rd_d = {4{32'h22220000 + p}};
      i_read = 1'b1; i_address = 16'h1000 + 16'(p * 16);
      d_read = 1'b1; d_address = 16'h2000 + 16'(p * 16);
      pushExpected(1'b0, rd_i);
      pushExpected(1'b1, rd_d);
      serve(1'b0, 1'b0, 16'h1000 + 16'(p * 16), 128'h0, 2, rd_i, 0);
      serve(1'b1, 1'b0, 16'h2000 + 16'(p * 16), 128'h0, 3, rd_d, 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("resp_count", resp_seen, resp_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
Two-port arbiter between the split L1 caches (instruction and data) and the shared L2 cache. It accepts line-granular miss and writeback requests from both L1s and grants one at a time using round-robin on ties. It latches the granted request and drives it to the L2 read/write/resp handshake. It returns the L2 line to the granted requester with a one-cycle response pulse. The instruction port is read-only.

Parameters:
ADDR_W, 16, byte address width on all ports
LINE_W, 128, cache line width on all data ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
i_address  in  ADDR_W  I-cache line address
i_read  in  1  I-cache read request, level, held until i_resp
i_rdata  out  LINE_W  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_address  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache writeback line
d_read  in  1  D-cache read request, level, held until d_resp
d_write  in  1  D-cache write request, level, held until d_resp
d_rdata  out  LINE_W  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
l2_address  out  ADDR_W  address to L2
l2_wdata  out  LINE_W  write line to L2
l2_read  out  1  read strobe to L2, level
l2_write  out  1  write strobe to L2, level
l2_rdata  in  LINE_W  line from L2, valid when l2_resp=1
l2_resp  in  1  L2 completion, single cycle

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all outputs 0; internal address, wdata, and rdata registers 0; last_grant=D, so I wins the first tie.
- States: IDLE, BUSY, DONE.
- IDLE, no request pending: remain in IDLE.
- IDLE, only I pending (i_read): grant I.
- IDLE, only D pending (d_read|d_write): grant D.
- IDLE, both pending: grant the port not equal to last_grant.
- On grant: latch address, wdata (D only), op, and granted port. Update last_grant. Go to BUSY.
- Op latch: d_read=1 with d_write=1 is a protocol violation and is latched as a write. I grants are always reads.
- BUSY: l2_address and l2_wdata come from the latched registers. Exactly one of l2_read/l2_write=1, held stable for the whole BUSY period. Requester inputs are ignored; changes or drops mid-transaction do not alter the L2 request.
- BUSY, l2_resp=1: capture l2_rdata into the granted port's rdata register (reads only; writes leave rdata unchanged). Go to DONE. l2_read/l2_write deassert in the DONE cycle.
- DONE: pulse i_resp or d_resp (granted port only) for exactly one cycle. Then return to IDLE.
- i_rdata/d_rdata are registered and hold their value until the next read completion on that port.
- Requesters must deassert their request in the cycle after the resp pulse. A request still high in IDLE is treated as a new request.
- Latency: request visible in IDLE cycle 0; l2 strobe asserted from cycle 1. If l2_resp arrives in cycle k, the resp pulse is in cycle k+1. Minimum request-to-resp is 3 cycles (l2_resp in cycle 1, resp in cycle 2).
- Never more than one outstanding L2 transaction. Never both i_resp and d_resp in the same cycle.
- l2_resp outside BUSY is ignored.
- Reset asserted in BUSY or DONE: abandon the transaction immediately. Strobes and resp go to 0 asynchronously. No resp is issued for the abandoned request.

Test Plan:
- I-only read: i_read=1, i_address=0x1230; L2 returns 0xAAAA…A with l2_resp 4 cycles after strobe -> l2_read=1 with l2_address=0x1230 from cycle 1; i_resp one cycle after l2_resp; i_rdata=0xAAAA…A; d_resp never asserts.
- D write: d_write=1, d_address=0x4440, d_wdata=0x55…5 -> l2_write=1 with l2_wdata=0x55…5 until l2_resp; d_resp single pulse; d_rdata unchanged.
- Simultaneous requests after reset: i_read and d_read both asserted in the same cycle -> I served first, D served next. Issue a second simultaneous pair -> order is I then D again (last_grant alternates correctly, no starvation).
- Request drop mid-BUSY: d_read deasserted two cycles into BUSY -> l2_read stays 1 and l2_address stays stable until l2_resp; d_resp still pulses once.
- Reset mid-transaction: rst_n pulled low during BUSY -> l2_read=0 immediately; after release, state=IDLE and no resp is issued; a new i_read completes normally.
- Spurious l2_resp=1 in IDLE and d_read=d_write=1 together -> spurious resp ignored with no output pulse; the conflicting request executes as an L2 write.
